// File: rtl/anc_error_tracker.sv
// anc_error_tracker: window lock tracker with hysteresis and a gain-shifted, saturated anti-noise error output
module anc_error_tracker #(
  parameter int DATA_WIDTH   = 16,
  parameter int THRESH_WIDTH = 8,
  parameter int LOCK_COUNT   = 256,
  parameter int UNLOCK_COUNT = 16,
  parameter int SHIFT_WIDTH  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          nc_on,
  input  logic                          error_ready,
  input  logic signed [DATA_WIDTH-1:0]  feedback_in,
  input  logic signed [THRESH_WIDTH-1:0] error_high_in,
  input  logic signed [THRESH_WIDTH-1:0] error_low_in,
  input  logic [SHIFT_WIDTH-1:0]        gain_shift_in,
  input  logic                          relock_in,
  output logic signed [DATA_WIDTH-1:0]  error_out,
  output logic                          error_locked_out,
  output logic                          done_out,
  output logic [1:0]                    state_out
);
  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {ACQUIRE = 2'd0, LOCKED = 2'd1, LOSING = 2'd2} state_t;
  state_t state;
  logic [HW-1:0] hit;
  logic [MW-1:0] miss;
  logic signed [DATA_WIDTH-1:0] hi_s, lo_s, neg, err;
  logic in_win;
  assign hi_s = DATA_WIDTH'(error_high_in);
  assign lo_s = DATA_WIDTH'(error_low_in);
  assign in_win = (lo_s < feedback_in) && (feedback_in < hi_s);
  assign neg = (feedback_in == MIN_V) ? MAX_V : -feedback_in;
  assign err = neg >>> gain_shift_in;
  assign state_out = state;
  assign error_locked_out = (state != ACQUIRE);
  // Tracking FSM plus the registered error/done stage; relock outranks the sample update
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ACQUIRE;
      hit       <= '0;
      miss      <= '0;
      error_out <= '0;
      done_out  <= 1'b0;
    end else begin
      done_out <= error_ready;
      if (error_ready)
        error_out <= ((state == ACQUIRE || relock_in) && nc_on) ? err : '0;
      if (relock_in) begin
        state <= ACQUIRE;
        hit   <= '0;
        miss  <= '0;
      end else if (error_ready) begin
        case (state)
          ACQUIRE: begin
            if (!in_win) hit <= '0;
            else if (hit == HW'(LOCK_COUNT - 1)) begin
              state <= LOCKED;
              hit   <= '0;
            end else hit <= hit + HW'(1);
          end
          LOCKED: begin
            if (!in_win) begin
              if (UNLOCK_COUNT == 1) begin
                state <= ACQUIRE;
                hit   <= '0;
                miss  <= '0;
              end else begin
                state <= LOSING;
                miss  <= MW'(1);
              end
            end
          end
          LOSING: begin
            if (in_win) begin
              state <= LOCKED;
              miss  <= '0;
            end else if (miss == MW'(UNLOCK_COUNT - 1)) begin
              state <= ACQUIRE;
              hit   <= '0;
              miss  <= '0;
            end else miss <= miss + MW'(1);
          end
          default: begin
            state <= ACQUIRE;
            hit   <= '0;
            miss  <= '0;
          end
        endcase
      end
    end
  end
endmodule
